// File: rtl/alu_arb.sv
// alu_arb: two-requester arbiter in front of one shared add/sltu ALU.
// One-entry result slot returns each result on its owner's channel.
module alu_arb #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_src1,
  input  logic [63:0] req0_src2,
  input  logic [1:0]  req0_aluop,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [63:0] resp0_result,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_src1,
  input  logic [63:0] req1_src2,
  input  logic [1:0]  req1_aluop,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [63:0] resp1_result
);

  logic        full;
  logic        owner;
  logic        last_grant;
  logic [63:0] result;

  logic        free;
  logic        gnt0;
  logic        gnt1;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic [63:0] sum;
  logic [63:0] ltu;
  logic [63:0] alu_out;

  // A full slot frees up in the same cycle its owner takes the result.
  assign free = !full || (owner ? resp1_ready : resp0_ready);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && free) begin
      unique case ({req1_valid, req0_valid})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          if (RR && !last_grant) gnt1 = 1'b1;
          else                   gnt0 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign a   = gnt1 ? req1_src1  : req0_src1;
  assign b   = gnt1 ? req1_src2  : req0_src2;
  assign op  = gnt1 ? req1_aluop : req0_aluop;
  assign sum = a + b;
  assign ltu = {63'd0, (a < b)};

  assign alu_out = (op[0] ? sum : 64'd0) | (op[1] ? ltu : 64'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result     <= 64'd0;
    end else if (gnt0 || gnt1) begin
      result     <= alu_out;
      owner      <= gnt1;
      full       <= 1'b1;
      last_grant <= gnt1;
    end else if (full && free) begin
      full <= 1'b0;
    end
  end

  assign resp0_valid  = full && !owner;
  assign resp1_valid  = full && owner;
  assign resp0_result = resp0_valid ? result : 64'd0;
  assign resp1_result = resp1_valid ? result : 64'd0;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: table-driven directed vectors for alu_arb,
// plus hand sequences for reset and fixed-priority checks.
module tb_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [1:0]  req0_aluop, req1_aluop;
  logic        resp0_ready, resp1_ready;

  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [63:0] resp0_result, resp1_result;

  logic        fp_req0_ready, fp_req1_ready;
  logic        fp_resp0_valid, fp_resp1_valid;
  logic [63:0] fp_resp0_result, fp_resp1_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arb #(.RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_aluop(req0_aluop),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_aluop(req1_aluop),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result)
  );

  alu_arb #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_aluop(req0_aluop),
    .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(fp_resp0_result),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_aluop(req1_aluop),
    .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(fp_resp1_result)
  );

  typedef struct {
    logic        v0;
    logic [1:0]  op0;
    logic [63:0] a0, b0;
    logic        v1;
    logic [1:0]  op1;
    logic [63:0] a1, b1;
    logic        rr0, rr1;
    logic        e_rdy0, e_rdy1;
    logic        e_v0;
    logic [63:0] e_r0;
    logic        e_v1;
    logic [63:0] e_r1;
    logic        fp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic v0, input logic [1:0] op0,
    input logic [63:0] a0, input logic [63:0] b0,
    input logic v1, input logic [1:0] op1,
    input logic [63:0] a1, input logic [63:0] b1,
    input logic rr0, input logic rr1,
    input logic e_rdy0, input logic e_rdy1,
    input logic e_v0, input logic [63:0] e_r0,
    input logic e_v1, input logic [63:0] e_r1,
    input logic fp);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr0 = rr0; v.rr1 = rr1;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1;
    v.e_v0 = e_v0; v.e_r0 = e_r0;
    v.e_v1 = e_v1; v.e_r1 = e_r1;
    v.fp = fp;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_aluop = v.op0;
    req0_src1 = v.a0;  req0_src2 = v.b0;
    req1_valid = v.v1; req1_aluop = v.op1;
    req1_src1 = v.a1;  req1_src2 = v.b1;
    resp0_ready = v.rr0; resp1_ready = v.rr1;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  initial begin
    // basic add, sltu, wrap, op 00, op 11, sltu edges
    tbl.push_back(mk(1,2'b01,5,3,     0,2'b00,0,0,   1,1, 1,0, 1,8,  0,0,   0));
    tbl.push_back(mk(0,2'b00,0,0,     1,2'b10,3,5,   1,1, 0,1, 0,0,  1,1,   0));
    tbl.push_back(mk(1,2'b01,ONES,1,  0,2'b00,0,0,   1,1, 1,0, 1,0,  0,0,   0));
    tbl.push_back(mk(1,2'b00,7,9,     0,2'b00,0,0,   1,1, 1,0, 1,0,  0,0,   0));
    tbl.push_back(mk(1,2'b11,2,4,     0,2'b00,0,0,   1,1, 1,0, 1,7,  0,0,   0));
    tbl.push_back(mk(0,2'b00,0,0,     1,2'b10,5,5,   1,1, 0,1, 0,0,  1,0,   0));
    tbl.push_back(mk(0,2'b00,0,0,     1,2'b10,MSB,1, 1,1, 0,1, 0,0,  1,0,   0));
    // round robin, responses always accepted
    tbl.push_back(mk(1,2'b01,1,1,     1,2'b01,2,2,   1,1, 1,0, 1,2,  0,0,   1));
    tbl.push_back(mk(1,2'b01,3,3,     1,2'b01,2,2,   1,1, 0,1, 0,0,  1,4,   1));
    tbl.push_back(mk(1,2'b01,3,3,     1,2'b01,4,4,   1,1, 1,0, 1,6,  0,0,   1));
    tbl.push_back(mk(1,2'b01,5,5,     1,2'b01,4,4,   1,1, 0,1, 0,0,  1,8,   1));
    // backpressure on requester 0 with requester 1 waiting
    tbl.push_back(mk(1,2'b01,10,20,   0,2'b00,0,0,   1,1, 1,0, 1,30, 0,0,   0));
    tbl.push_back(mk(0,2'b00,0,0,     1,2'b01,100,1, 0,1, 0,0, 1,30, 0,0,   0));
    tbl.push_back(mk(0,2'b00,0,0,     1,2'b01,100,1, 0,1, 0,0, 1,30, 0,0,   0));
    tbl.push_back(mk(0,2'b00,0,0,     1,2'b01,100,1, 0,1, 0,0, 1,30, 0,0,   0));
    tbl.push_back(mk(0,2'b00,0,0,     1,2'b01,100,1, 1,1, 0,1, 0,0,  1,101, 0));
    tbl.push_back(mk(0,2'b00,0,0,     0,2'b00,0,0,   1,1, 0,0, 0,0,  0,0,   0));

    // reset state, with a request pending
    rst_n = 1'b0;
    drive(mk(1,2'b01,5,3, 1,2'b01,1,1, 1,1, 0,0, 0,0, 0,0, 0));
    #2;
    chk("rst_req0_ready", 0, req0_ready, 0);
    chk("rst_req1_ready", 0, req1_ready, 0);
    chk("rst_resp0_valid", 0, resp0_valid, 0);
    chk("rst_resp1_valid", 0, resp1_valid, 0);
    chk("rst_resp0_result", 0, resp0_result, 0);
    chk("rst_resp1_result", 0, resp1_result, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("req0_ready", i, req0_ready, tbl[i].e_rdy0);
      chk("req1_ready", i, req1_ready, tbl[i].e_rdy1);
      if (tbl[i].fp) begin
        chk("fp_req0_ready", i, fp_req0_ready, 1);
        chk("fp_req1_ready", i, fp_req1_ready, 0);
      end
      @(posedge clk);
      #1;
      chk("resp0_valid", i, resp0_valid, tbl[i].e_v0);
      chk("resp0_result", i, resp0_result, tbl[i].e_r0);
      chk("resp1_valid", i, resp1_valid, tbl[i].e_v1);
      chk("resp1_result", i, resp1_result, tbl[i].e_r1);
    end

    // async reset while a result is held for requester 0
    @(negedge clk);
    drive(mk(1,2'b01,1,2, 0,2'b00,0,0, 0,0, 0,0, 0,0, 0,0, 0));
    @(posedge clk);
    #1;
    chk("hold_resp0_valid", 100, resp0_valid, 1);
    chk("hold_resp0_result", 100, resp0_result, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_resp0_valid", 101, resp0_valid, 0);
    chk("arst_resp0_result", 101, resp0_result, 0);
    chk("arst_req0_ready", 101, req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1,2'b01,1,1, 1,2'b01,2,2, 1,1, 0,0, 0,0, 0,0, 0));
    #1;
    chk("post_rst_req0_ready", 102, req0_ready, 1);
    chk("post_rst_req1_ready", 102, req1_ready, 0);
    @(posedge clk);
    #1;
    chk("post_rst_resp0_valid", 103, resp0_valid, 1);
    chk("post_rst_resp0_result", 103, resp0_result, 2);
    chk("post_rst_resp1_valid", 103, resp1_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Two-requester arbiter and sequencer in front of one shared combinational ALU instance (aluop bit0 = add, bit1 = sltu; 64-bit operands and result).
- Grants one request per cycle to requester 0 (execute stage) or requester 1 (auxiliary address/compare user).
- Evaluates the granted operation on the shared ALU and registers the result.
- Returns the result on the owning requester's response channel with valid/ready handshake.

Parameters:
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_src1  input  64  operand 1
- req0_src2  input  64  operand 2
- req0_aluop  input  2  bit0 add, bit1 sltu
- resp0_valid  output  1  result pending for requester 0
- resp0_ready  input  1  requester 0 takes result
- resp0_result  output  64  result for requester 0
- req1_valid / req1_ready / req1_src1 / req1_src2 / req1_aluop  same widths and meaning as requester 0, for requester 1
- resp1_valid / resp1_ready / resp1_result  same widths and meaning as requester 0, for requester 1

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed): result slot empty, owner=0, result reg=0, last_grant=1. While held: resp0_valid=0, resp1_valid=0, req0_ready=0, req1_ready=0, resp*_result=0.
- Slot states:
  - EMPTY: no result held.
  - FULL: result held for owner.
- free = EMPTY, or (FULL and the owner's resp_ready=1 this cycle).
- Grant is computed combinationally each cycle, only when free=1:
  - Only one reqN_valid high: grant N.
  - Both high, RR=1: grant the requester that is not last_grant.
  - Both high, RR=0: grant 0.
  - Neither high: no grant.
- reqN_ready = grant to N. A transfer occurs when reqN_valid and reqN_ready are both high at the rising edge.
- On transfer from N:
  - Result reg <= shared ALU output for reqN operands/aluop.
  - owner <= N, slot <= FULL, last_grant <= N.
- On FULL with owner's resp_ready=1 and no new transfer: slot <= EMPTY.
- respN_valid = FULL and owner==N. respN_result = result reg when respN_valid=1, else 0.
- Latency: transfer at edge k -> respN_valid high from edge k to at least edge k+1.
- Throughput: one operation per cycle when responses are accepted immediately. Same-cycle drain and refill is mandatory.
- Backpressure: while FULL and the owner's resp_ready=0:
  - Both reqN_ready stay 0.
  - Result reg, owner and respN_valid are stable.
  - The non-owner response stays 0.
- Arithmetic (shared ALU, no flags):
  - add is modulo 2^64.
  - sltu is an unsigned compare, zero-extended to 64 bits.
  - aluop 2'b00 -> 0.
  - aluop 2'b11 -> OR of add and sltu results.
  - All four codes are accepted; none is rejected.
- Requester obligations: hold reqN_* stable from valid high until transfer. The arbiter does not check this.
- Grant is never given to a requester whose valid is low. The response is never presented on the wrong channel.
- RR fairness: with both valid continuously and responses always accepted, grants alternate 0,1,0,1...
- Reset mid-operation: held result is dropped without handshake; first grant after release favours requester 0.

Test Plan:
- Basic add: reset, req0 add src1=5 src2=3 -> req0_ready=1 that cycle; next cycle resp0_valid=1, resp0_result=8; resp1_valid=0.
- Sltu and wrap: req1 sltu 3 vs 5 -> resp1_result=1. Then req0 add 0xFFFF_FFFF_FFFF_FFFF + 1 -> resp0_result=0. Then aluop=00 -> 0.
- Round-robin, both resp_ready=1: req0 and req1 both valid for 4 cycles with distinct adds (1+1, 2+2, ...). Grants go 0,1,0,1; responses alternate channels with correct sums; one result per cycle. With RR=0, all four grants go to requester 0.
- Backpressure: resp0_ready=0 for 3 cycles while req1 is valid. Required: req1_ready=0, resp0_result stable for 3 cycles. When resp0_ready rises, req1 is granted in the same cycle and resp1_valid appears next cycle.
- Async reset while FULL: assert rst_n low mid-cycle. resp*_valid drops before the next clock edge. After release with both requesting, requester 0 is granted first.
